spi_shift_engine: RTL and testbench

- Byte-serial SPI master engine driven directly by the AHB SPI peripheral's control logic: spi_enable, write data, byte count in; received data, byte progress and ready out.
- Shifts 1-4 bytes per transfer, MSB first within each byte, with a programmable SCLK divider and per-transfer CPOL/CPHA.
- Slave select stays outside this block, in the AHB peripheral.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_shift_engine_if.sv | 24 ++
 rtl/spi_clk_tick.sv | 34 +++
 rtl/spi_shift_engine.sv | 188 ++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine: FSM encoding,
// legal byte-count window and SPI mode encodings.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_TRAIL,
        ST_DONE
    } spi_state_e;

    localparam int BUS_W     = 32;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] BYTES_MIN = 3'd1;
    localparam logic [2:0] BYTES_MAX = 3'd4;

    localparam logic CPOL_IDLE_LOW     = 1'b0;
    localparam logic CPOL_IDLE_HIGH    = 1'b1;
    localparam logic CPHA_LEAD_SAMPLE  = 1'b0;
    localparam logic CPHA_TRAIL_SAMPLE = 1'b1;

    function automatic logic bytes_legal(input logic [2:0] n);
        return (n >= BYTES_MIN) && (n <= BYTES_MAX);
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Control/status bus between the AHB SPI peripheral (master side) and the
// shift engine (slave side).
interface spi_shift_engine_if;

    logic                        enable_i;
    logic                        cpol_i;
    logic                        cpha_i;
    logic [spi_pkg::BUS_W-1:0]   spi_write_data_i;
    logic [2:0]                  spi_write_data_bytes_valid_i;
    logic [spi_pkg::BUS_W-1:0]   spi_read_data_o;
    logic [2:0]                  spi_read_data_bytes_valid_o;
    logic                        ready_o;

    modport master (
        output enable_i, cpol_i, cpha_i, spi_write_data_i, spi_write_data_bytes_valid_i,
        input  spi_read_data_o, spi_read_data_bytes_valid_o, ready_o
    );

    modport slave (
        input  enable_i, cpol_i, cpha_i, spi_write_data_i, spi_write_data_bytes_valid_i,
        output spi_read_data_o, spi_read_data_bytes_valid_o, ready_o
    );

endinterface

// File: rtl/spi_clk_tick.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV cycles while
// running; cleared at transfer start so the first half-period is full length.
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (run_i) begin
            cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-serial SPI master: shifts 1-4 bytes MSB-first per transfer with
// per-transfer CPOL/CPHA; slave select lives in the AHB peripheral.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_shift_engine_if.slave  bus,
    input  logic               spi_miso_i,
    output logic               spi_mosi_o,
    output logic               spi_clk_o
);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        bv_q, bv_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              armed_q, armed_d;
    logic              ready_q, ready_d;
    logic              bv_inc_q, bv_inc_d;

    logic              start;
    logic              running;
    logic              tick;
    logic              sample;
    logic [2:0]        nxt_bit;
    logic [1:0]        nxt_byte;

    assign start   = (state_q == ST_IDLE) && bus.enable_i && armed_q
                     && bytes_legal(bus.spi_write_data_bytes_valid_i);
    assign running = (state_q == ST_LEAD) || (state_q == ST_TRAIL);
    assign nxt_bit  = bit_cnt_q + 3'd1;
    assign nxt_byte = byte_idx_q + 2'd1;

    // MISO is captured on the leading edge for CPHA=0, trailing edge for CPHA=1.
    assign sample = tick && (((state_q == ST_LEAD)  && (cpha_q == CPHA_LEAD_SAMPLE)) ||
                             ((state_q == ST_TRAIL) && (cpha_q == CPHA_TRAIL_SAMPLE)));

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (start),
        .run_i  (running),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rd_d       = rd_q;
        nbytes_d   = nbytes_q;
        bv_d       = bv_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        bv_inc_d   = 1'b0;
        armed_d    = bus.enable_i ? armed_q : 1'b1;

        // Byte count lags the lane write by one cycle.
        if (bv_inc_q) begin
            bv_d = bv_q + 3'd1;
        end

        if (sample) begin
            rx_d = {rx_q[5:0], spi_miso_i};
            if (bit_cnt_q == 3'd7) begin
                rd_d[{byte_idx_q, 3'b000} +: 8] = {rx_q, spi_miso_i};
                bv_inc_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = bus.cpol_i;
                if (start) begin
                    tx_d       = bus.spi_write_data_i;
                    nbytes_d   = bus.spi_write_data_bytes_valid_i;
                    cpol_d     = bus.cpol_i;
                    cpha_d     = bus.cpha_i;
                    rd_d       = '0;
                    bv_d       = 3'd0;
                    armed_d    = 1'b0;
                    byte_idx_d = 2'd0;
                    bit_cnt_d  = 3'd0;
                    mosi_d     = bus.spi_write_data_i[7];
                    state_d    = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    sclk_d  = ~cpol_q;
                    state_d = ST_TRAIL;
                    if (cpha_q == CPHA_TRAIL_SAMPLE) begin
                        mosi_d = tx_q[{byte_idx_q, ~bit_cnt_q}];
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    sclk_d = cpol_q;
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = nxt_bit;
                        state_d   = ST_LEAD;
                        if (cpha_q == CPHA_LEAD_SAMPLE) begin
                            mosi_d = tx_q[{byte_idx_q, ~nxt_bit}];
                        end
                    end else if ((({1'b0, byte_idx_q} + 3'd1) < nbytes_q) && bus.enable_i) begin
                        // Back-to-back byte: no gap cycle between bytes.
                        byte_idx_d = nxt_byte;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_LEAD;
                        if (cpha_q == CPHA_LEAD_SAMPLE) begin
                            mosi_d = tx_q[{nxt_byte, 3'b111}];
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rd_q       <= '0;
            nbytes_q   <= 3'd0;
            bv_q       <= 3'd0;
            byte_idx_q <= 2'd0;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 7'd0;
            cpol_q     <= CPOL_IDLE_LOW;
            cpha_q     <= CPHA_LEAD_SAMPLE;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            armed_q    <= 1'b1;
            ready_q    <= 1'b1;
            bv_inc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rd_q       <= rd_d;
            nbytes_q   <= nbytes_d;
            bv_q       <= bv_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            armed_q    <= armed_d;
            ready_q    <= ready_d;
            bv_inc_q   <= bv_inc_d;
        end
    end

    assign spi_mosi_o                      = mosi_q;
    assign spi_clk_o                       = sclk_q;
    assign bus.spi_read_data_o             = rd_q;
    assign bus.spi_read_data_bytes_valid_o = bv_q;
    assign bus.ready_o                     = ready_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: SPI slave model on the serial pins, vector
// table plus random transfers, and hand sequences for stop/re-arm/reset.
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;
    logic miso, mosi, sclk;

    always #5 clk = ~clk;

    spi_shift_engine_if bus ();

    spi_shift_engine #(.CLK_DIV(CLK_DIV), .DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .spi_miso_i (miso),
        .spi_mosi_o (mosi),
        .spi_clk_o  (sclk)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- SPI slave model (byte lane k travels k-th, MSB first) ----
    logic        s_cpol = 1'b0, s_cpha = 1'b0, s_loop = 1'b0, s_arm = 1'b0;
    logic [31:0] s_data = '0;
    logic [31:0] cap_data;
    int          cap_bits, s_bit, sclk_edges;
    logic        sclk_prev, miso_reg;

    assign miso = s_loop ? mosi : miso_reg;

    function automatic logic stream_bit(input logic [31:0] d, input int i);
        if (i < 0 || i > 31) return 1'b0;
        return d[(i / 8) * 8 + 7 - (i % 8)];
    endfunction

    always @(negedge clk) begin
        if (s_arm) begin
            cap_data   <= '0;
            cap_bits   <= 0;
            sclk_edges <= 0;
            s_bit      <= 0;
            sclk_prev  <= sclk;
            miso_reg   <= s_cpha ? 1'b0 : stream_bit(s_data, 0);
        end else begin
            if (sclk != sclk_prev) begin
                sclk_edges <= sclk_edges + 1;
                if ((sclk != s_cpol) ^ s_cpha) begin
                    if (cap_bits < 32) cap_data[(cap_bits / 8) * 8 + 7 - (cap_bits % 8)] <= mosi;
                    cap_bits <= cap_bits + 1;
                end
                if (sclk != s_cpol && s_cpha) begin
                    miso_reg <= stream_bit(s_data, s_bit);
                    s_bit    <= s_bit + 1;
                end else if (sclk == s_cpol && !s_cpha) begin
                    miso_reg <= stream_bit(s_data, s_bit + 1);
                    s_bit    <= s_bit + 1;
                end
            end
            sclk_prev <= sclk;
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input int n);
        logic [31:0] m = '0;
        for (int k = 0; k < n; k++) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer. cyc counts clocks from the start cycle until ready_o
    // is seen high again; a full N-byte transfer takes 16*N*CLK_DIV+2.
    task automatic run_xfer(input string nm, input logic cpol, input logic cpha,
                            input logic [2:0] n, input logic [31:0] tx, input logic [31:0] sd,
                            input logic loopb, input int drop_cyc, input logic hold,
                            input logic [31:0] exp_rd, input logic [31:0] exp_mosi,
                            input logic [2:0] exp_bv, input int exp_cyc);
        int   cyc;
        logic done, steps_ok;
        logic [2:0] last_bv;
        bus.enable_i = 1'b0;
        bus.cpol_i = cpol;
        bus.cpha_i = cpha;
        bus.spi_write_data_i = tx;
        bus.spi_write_data_bytes_valid_i = n;
        s_cpol = cpol; s_cpha = cpha; s_loop = loopb; s_data = sd;
        tick1();
        s_arm = 1'b1;
        bus.enable_i = 1'b1;
        cyc = 0; done = 1'b0; steps_ok = 1'b1; last_bv = 3'd0;
        while (!done && cyc < 2000) begin
            tick1();
            s_arm = 1'b0;
            cyc++;
            if (cyc == 3) begin
                // latched inputs must not follow the bus once started
                bus.spi_write_data_i = $urandom;
                bus.spi_write_data_bytes_valid_i = 3'($urandom_range(0, 7));
                bus.cpha_i = 1'($urandom);
            end
            if (cyc == drop_cyc) bus.enable_i = 1'b0;
            if (bus.spi_read_data_bytes_valid_o != last_bv) begin
                if (bus.spi_read_data_bytes_valid_o != last_bv + 3'd1) steps_ok = 1'b0;
                last_bv = bus.spi_read_data_bytes_valid_o;
            end
            if (cyc > 1 && bus.ready_o) done = 1'b1;
        end
        if (!hold) bus.enable_i = 1'b0;
        check({nm, " start_to_ready"}, 32'(cyc), 32'(exp_cyc));
        check({nm, " rd_data"}, bus.spi_read_data_o, exp_rd);
        check({nm, " bytes_valid"}, 32'(bus.spi_read_data_bytes_valid_o), 32'(exp_bv));
        check({nm, " mosi_bytes"}, cap_data, exp_mosi);
        check({nm, " sclk_edges"}, 32'(sclk_edges), 32'(16 * int'(exp_bv)));
        check({nm, " sclk_idle"}, 32'(sclk), 32'(cpol));
        check({nm, " bv_steps"}, 32'(steps_ok), 32'd1);
    endtask

    typedef struct {
        string       nm;
        logic        cpol, cpha;
        logic [2:0]  n;
        logic [31:0] tx, sd;
        logic        loopb;
        logic [31:0] exp_rd, exp_mosi;
        logic [2:0]  exp_bv;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ready_low, edges0;
        logic [2:0] rn;
        logic [31:0] rtx, rsd;
        logic rl;

        vecs[0] = '{"m0_a5",   1'b0, 1'b0, 3'd1, 32'h000000A5, 32'h0,        1'b1, 32'h000000A5, 32'h000000A5, 3'd1, 66};
        vecs[1] = '{"m3_n4",   1'b1, 1'b1, 3'd4, 32'h12345678, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE, 32'h12345678, 3'd4, 258};
        vecs[2] = '{"m1_n2",   1'b0, 1'b1, 3'd2, 32'h0000BEEF, 32'h00003C5A, 1'b0, 32'h00003C5A, 32'h0000BEEF, 3'd2, 130};
        vecs[3] = '{"m2_n3",   1'b1, 1'b0, 3'd3, 32'h77C0FFEE, 32'h0,        1'b1, 32'h00C0FFEE, 32'h00C0FFEE, 3'd3, 194};

        rst = 1'b1;
        bus.enable_i = 1'b0; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
        bus.spi_write_data_i = '0; bus.spi_write_data_bytes_valid_i = 3'd1;
        tick1();
        tick1();
        check("reset mosi",  32'(mosi), 32'd0);
        check("reset sclk",  32'(sclk), 32'd0);
        check("reset rd",    bus.spi_read_data_o, 32'd0);
        check("reset bv",    32'(bus.spi_read_data_bytes_valid_o), 32'd0);
        check("reset ready", 32'(bus.ready_o), 32'd1);
        rst = 1'b0;
        tick1();

        for (int i = 0; i < 4; i++)
            run_xfer(vecs[i].nm, vecs[i].cpol, vecs[i].cpha, vecs[i].n, vecs[i].tx, vecs[i].sd,
                     vecs[i].loopb, -1, 1'b0, vecs[i].exp_rd, vecs[i].exp_mosi,
                     vecs[i].exp_bv, vecs[i].exp_cyc);

        // randomized transfers against the lane-level model
        for (int i = 0; i < 6; i++) begin
            rn  = 3'($urandom_range(1, 4));
            rtx = $urandom;
            rsd = $urandom;
            rl  = 1'($urandom);
            run_xfer($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), rn, rtx, rsd, rl, -1, 1'b0,
                     (rl ? rtx : rsd) & lane_mask(int'(rn)), rtx & lane_mask(int'(rn)),
                     rn, 16 * int'(rn) * CLK_DIV + 2);
        end

        // enable dropped in the middle of byte 1: byte 1 finishes, then stop
        run_xfer("drop", 1'b0, 1'b0, 3'd4, 32'h11223344, 32'hA1B2C3D4, 1'b0, 84, 1'b0,
                 32'h0000C3D4, 32'h00003344, 3'd2, 130);

        // enable held through DONE must not retrigger
        run_xfer("hold", 1'b0, 1'b1, 3'd1, 32'h0000003C, 32'h00000096, 1'b0, -1, 1'b1,
                 32'h00000096, 32'h0000003C, 3'd1, 66);
        ready_low = 0;
        edges0 = sclk_edges;
        for (int c = 0; c < 24; c++) begin
            tick1();
            if (!bus.ready_o) ready_low++;
        end
        check("hold no_retrigger ready", 32'(ready_low), 32'd0);
        check("hold no_retrigger sclk", 32'(sclk_edges - edges0), 32'd0);
        run_xfer("rearm", 1'b0, 1'b0, 3'd2, 32'h00005AA5, 32'h0000F00F, 1'b0, -1, 1'b0,
                 32'h0000F00F, 32'h00005AA5, 3'd2, 130);

        // illegal byte counts are ignored
        foreach (rtx[k]) begin
            if (k > 1) break;
            bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_loop = 1'b0;
            bus.spi_write_data_bytes_valid_i = (k == 0) ? 3'd0 : 3'd5;
            bus.enable_i = 1'b0;
            tick1();
            s_arm = 1'b1;
            bus.enable_i = 1'b1;
            ready_low = 0;
            for (int c = 0; c < 20; c++) begin
                tick1();
                s_arm = 1'b0;
                if (!bus.ready_o) ready_low++;
            end
            bus.enable_i = 1'b0;
            check($sformatf("illegal_bytes%0d ready", k), 32'(ready_low), 32'd0);
            check($sformatf("illegal_bytes%0d sclk", k), 32'(sclk_edges), 32'd0);
        end

        // reset mid-bit aborts immediately
        bus.enable_i = 1'b0; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
        bus.spi_write_data_i = 32'hDEADBEEF; bus.spi_write_data_bytes_valid_i = 3'd4;
        tick1();
        bus.enable_i = 1'b1;
        for (int c = 0; c < 37; c++) tick1();
        rst = 1'b1;
        tick1();
        check("midrst mosi",  32'(mosi), 32'd0);
        check("midrst sclk",  32'(sclk), 32'd0);
        check("midrst rd",    bus.spi_read_data_o, 32'd0);
        check("midrst bv",    32'(bus.spi_read_data_bytes_valid_o), 32'd0);
        check("midrst ready", 32'(bus.ready_o), 32'd1);
        rst = 1'b0;
        bus.enable_i = 1'b0;
        run_xfer("post_rst", 1'b0, 1'b0, 3'd3, 32'h00ABCDEF, 32'h00135724, 1'b0, -1, 1'b0,
                 32'h00135724, 32'h00ABCDEF, 3'd3, 194);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
